// File: rtl/datapath_pkg.sv
// Shared encodings for the Mini SRC datapath: bus source selects and ALU opcodes.
package datapath_pkg;

    localparam logic [4:0] SEL_R0  = 5'd0;
    localparam logic [4:0] SEL_HI  = 5'd16;
    localparam logic [4:0] SEL_LO  = 5'd17;
    localparam logic [4:0] SEL_ZHI = 5'd18;
    localparam logic [4:0] SEL_ZLO = 5'd19;
    localparam logic [4:0] SEL_PC  = 5'd20;
    localparam logic [4:0] SEL_MDR = 5'd21;
    localparam logic [4:0] SEL_IR  = 5'd22;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SHR  = 4'b0100;
    localparam logic [3:0] OP_SHRA = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_ROL  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_NEG  = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;

endpackage

// File: rtl/datapath_if.sv
// Per-cycle control bundle from the control unit into the datapath,
// plus the memory address held in MAR.
interface datapath_if #(parameter int WIDTH = 32);
    logic             incPC;
    logic [3:0]       GP_addr;
    logic [WIDTH-1:0] Mdatain;
    logic             MDR_read;
    logic             e_PC;
    logic             e_IR;
    logic             e_Y;
    logic             e_Z;
    logic             e_HI;
    logic             e_LO;
    logic             e_MDR;
    logic             e_MAR;
    logic             e_GP;
    logic [3:0]       ALU_op;
    logic [4:0]       BusDataSelect;
    logic [WIDTH-1:0] address;

    modport master (
        output incPC, GP_addr, Mdatain, MDR_read,
        output e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
        output e_MDR, e_MAR, e_GP, ALU_op, BusDataSelect,
        input  address
    );

    modport slave (
        input  incPC, GP_addr, Mdatain, MDR_read,
        input  e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
        input  e_MDR, e_MAR, e_GP, ALU_op, BusDataSelect,
        output address
    );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 2*WIDTH result feeds Z.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    input  logic               inc_pc,
    output logic [2*WIDTH-1:0] result
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [SW-1:0]      sh;
    logic [2*WIDTH-1:0] ror_w;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] sa;
    logic [2*WIDTH-1:0] sb;

    assign sh    = b[SW-1:0];
    assign ror_w = {a, a} >> sh;
    assign rol_w = {a, a} << sh;
    assign sa    = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb    = {{WIDTH{b[WIDTH-1]}}, b};

    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[WIDTH-1:0] = b + WIDTH'(1);
        end else begin
            case (op)
                OP_ADD:  result[WIDTH-1:0] = a + b;
                OP_SUB:  result[WIDTH-1:0] = a - b;
                OP_AND:  result[WIDTH-1:0] = a & b;
                OP_OR:   result[WIDTH-1:0] = a | b;
                OP_SHR:  result[WIDTH-1:0] = a >> sh;
                OP_SHRA: result[WIDTH-1:0] = $signed(a) >>> sh;
                OP_SHL:  result[WIDTH-1:0] = a << sh;
                OP_ROR:  result[WIDTH-1:0] = ror_w[WIDTH-1:0];
                OP_ROL:  result[WIDTH-1:0] = rol_w[2*WIDTH-1:WIDTH];
                OP_MUL:  result = sa * sb;
                OP_DIV: begin
                    // Divide-by-zero and MIN/-1 overflow get fixed results
                    if (b == '0) begin
                        result = {a, {WIDTH{1'b1}}};
                    end else if (a == MIN_INT && b == '1) begin
                        result = {{WIDTH{1'b0}}, a};
                    end else begin
                        result[WIDTH-1:0]       = $signed(a) / $signed(b);
                        result[2*WIDTH-1:WIDTH] = $signed(a) % $signed(b);
                    end
                end
                OP_NEG:  result[WIDTH-1:0] = '0 - b;
                OP_NOT:  result[WIDTH-1:0] = ~b;
                default: result[WIDTH-1:0] = b;
            endcase
        end
    end
endmodule

// File: rtl/datapath.sv
// Mini SRC single-bus datapath: register file, special registers,
// bus source mux and ALU, all sequenced externally cycle by cycle.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clock,
    input logic       clear,
    datapath_if.slave d
);
    logic [WIDTH-1:0]   r [16];
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   ir;
    logic [WIDTH-1:0]   y;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mdr;
    logic [WIDTH-1:0]   mar;
    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_res;

    always_comb begin
        bus = '0;
        if (d.BusDataSelect < SEL_HI) begin
            bus = r[d.BusDataSelect[3:0]];
        end else begin
            case (d.BusDataSelect)
                SEL_HI:  bus = hi;
                SEL_LO:  bus = lo;
                SEL_ZHI: bus = z[2*WIDTH-1:WIDTH];
                SEL_ZLO: bus = z[WIDTH-1:0];
                SEL_PC:  bus = pc;
                SEL_MDR: bus = mdr;
                SEL_IR:  bus = ir;
                default: bus = '0;
            endcase
        end
    end

    datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (y),
        .b      (bus),
        .op     (d.ALU_op),
        .inc_pc (d.incPC),
        .result (alu_res)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            z   <= '0;
            hi  <= '0;
            lo  <= '0;
            mdr <= '0;
            mar <= '0;
        end else begin
            if (d.e_PC)  pc  <= bus;
            if (d.e_IR)  ir  <= bus;
            if (d.e_Y)   y   <= bus;
            if (d.e_Z)   z   <= alu_res;
            if (d.e_HI)  hi  <= bus;
            if (d.e_LO)  lo  <= bus;
            if (d.e_MAR) mar <= bus;
            if (d.e_GP)  r[d.GP_addr] <= bus;
            if (d.e_MDR) mdr <= d.MDR_read ? d.Mdatain : bus;
        end
    end

    assign d.address = mar;
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: reference model of the register state checked every
// cycle, plus literal expectations from hand-worked micro-sequences.
module tb_datapath;
    logic clock = 1'b0;
    logic clear = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    datapath_if dif ();

    datapath dut (
        .clock (clock),
        .clear (clear),
        .d     (dif)
    );

    always #5 clock = ~clock;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mdr, m_mar;
    logic [63:0] m_z;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_bus(logic [4:0] s);
        if (s < 5'd16) return m_r[s[3:0]];
        case (s)
            5'd16:   return m_hi;
            5'd17:   return m_lo;
            5'd18:   return m_z[63:32];
            5'd19:   return m_z[31:0];
            5'd20:   return m_pc;
            5'd21:   return m_mdr;
            5'd22:   return m_ir;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] ref_alu(logic [31:0] a, logic [31:0] b,
                                            logic [3:0] op, logic inc);
        int sa = a;
        int sb = b;
        int n = int'(b[4:0]);
        logic [31:0] x = a;
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            4'd0:  return {32'h0, a + b};
            4'd1:  return {32'h0, a - b};
            4'd2:  return {32'h0, a & b};
            4'd3:  return {32'h0, a | b};
            4'd4:  return {32'h0, a >> n};
            4'd5:  return {32'h0, 32'(sa >>> n)};
            4'd6:  return {32'h0, a << n};
            4'd7: begin
                repeat (n) x = {x[0], x[31:1]};
                return {32'h0, x};
            end
            4'd8: begin
                repeat (n) x = {x[30:0], x[31]};
                return {32'h0, x};
            end
            4'd9:  return 64'(longint'(sa) * longint'(sb));
            4'd10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd11: return {32'h0, 32'h0 - b};
            4'd12: return {32'h0, ~b};
            default: return {32'h0, b};
        endcase
    endfunction

    always @(posedge clock) begin : model
        logic [31:0] bv;
        logic [63:0] av;
        bv = ref_bus(dif.BusDataSelect);
        av = ref_alu(m_y, bv, dif.ALU_op, dif.incPC);
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
            {m_pc, m_ir, m_y, m_hi, m_lo, m_mdr, m_mar} = '0;
            m_z = 64'h0;
        end else begin
            if (dif.e_PC)  m_pc  = bv;
            if (dif.e_IR)  m_ir  = bv;
            if (dif.e_Y)   m_y   = bv;
            if (dif.e_Z)   m_z   = av;
            if (dif.e_HI)  m_hi  = bv;
            if (dif.e_LO)  m_lo  = bv;
            if (dif.e_MAR) m_mar = bv;
            if (dif.e_GP)  m_r[dif.GP_addr] = bv;
            if (dif.e_MDR) m_mdr = dif.MDR_read ? dif.Mdatain : bv;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < 16; i++)
                chk($sformatf("R%0d", i), {32'h0, dut.r[i]}, {32'h0, m_r[i]});
            chk("PC", {32'h0, dut.pc}, {32'h0, m_pc});
            chk("IR", {32'h0, dut.ir}, {32'h0, m_ir});
            chk("Y", {32'h0, dut.y}, {32'h0, m_y});
            chk("Z", dut.z, m_z);
            chk("HI", {32'h0, dut.hi}, {32'h0, m_hi});
            chk("LO", {32'h0, dut.lo}, {32'h0, m_lo});
            chk("MDR", {32'h0, dut.mdr}, {32'h0, m_mdr});
            chk("MAR", {32'h0, dif.address}, {32'h0, m_mar});
        end
    end

    task automatic idle();
        clear = 1'b0;
        dif.incPC = 1'b0;
        dif.GP_addr = 4'd0;
        dif.Mdatain = 32'h0;
        dif.MDR_read = 1'b0;
        dif.e_PC = 1'b0;
        dif.e_IR = 1'b0;
        dif.e_Y = 1'b0;
        dif.e_Z = 1'b0;
        dif.e_HI = 1'b0;
        dif.e_LO = 1'b0;
        dif.e_MDR = 1'b0;
        dif.e_MAR = 1'b0;
        dif.e_GP = 1'b0;
        dif.ALU_op = 4'd0;
        dif.BusDataSelect = 5'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(logic [31:0] v);
        dif.Mdatain = v;
        dif.MDR_read = 1'b1;
        dif.e_MDR = 1'b1;
        tick();
    endtask

    task automatic load_reg(int idx, logic [31:0] v);
        load_mdr(v);
        dif.BusDataSelect = 5'd21;
        dif.GP_addr = 4'(idx);
        dif.e_GP = 1'b1;
        tick();
    endtask

    task automatic load_y(logic [31:0] v);
        load_mdr(v);
        dif.BusDataSelect = 5'd21;
        dif.e_Y = 1'b1;
        tick();
    endtask

    task automatic alu_z(int src, logic [3:0] op);
        dif.BusDataSelect = 5'(src);
        dif.ALU_op = op;
        dif.e_Z = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        clear = 1'b1;
        tick();
        cmp_en = 1'b1;
        dif.BusDataSelect = 5'd19;
        #1;
        chk("reset_bus_zlo", {32'h0, dut.bus}, 64'h0);
        chk("reset_pc", {32'h0, dut.pc}, 64'h0);
        idle();

        dif.BusDataSelect = 5'd20;
        dif.e_MAR = 1'b1;
        dif.incPC = 1'b1;
        dif.e_Z = 1'b1;
        tick();
        chk("fetch_mar", {32'h0, dif.address}, 64'h0);
        chk("fetch_z", dut.z, 64'h1);
        dif.BusDataSelect = 5'd19;
        dif.e_PC = 1'b1;
        dif.MDR_read = 1'b1;
        dif.e_MDR = 1'b1;
        dif.Mdatain = 32'h2A348000;
        tick();
        chk("fetch_pc", {32'h0, dut.pc}, 64'h1);
        chk("fetch_mdr", {32'h0, dut.mdr}, 64'h2A348000);
        dif.BusDataSelect = 5'd21;
        dif.e_IR = 1'b1;
        tick();
        chk("fetch_ir", {32'h0, dut.ir}, 64'h2A348000);

        load_reg(0, 32'd5);
        alu_z(0, 4'b1011);
        chk("neg_z", dut.z, 64'h00000000_FFFFFFFB);
        dif.BusDataSelect = 5'd19;
        dif.GP_addr = 4'd5;
        dif.e_GP = 1'b1;
        tick();
        chk("neg_r5", {32'h0, dut.r[5]}, 64'hFFFFFFFB);

        load_y(32'hFFFFFFFE);
        load_reg(1, 32'd3);
        alu_z(1, 4'b1001);
        chk("mul_z", dut.z, 64'hFFFFFFFF_FFFFFFFA);
        dif.BusDataSelect = 5'd18;
        dif.e_HI = 1'b1;
        tick();
        dif.BusDataSelect = 5'd19;
        dif.e_LO = 1'b1;
        tick();
        chk("mul_hi", {32'h0, dut.hi}, 64'hFFFFFFFF);
        chk("mul_lo", {32'h0, dut.lo}, 64'hFFFFFFFA);

        load_y(32'd7);
        load_reg(2, 32'd2);
        load_reg(3, 32'd0);
        alu_z(2, 4'b1010);
        chk("div_z", dut.z, {32'd1, 32'd3});
        alu_z(3, 4'b1010);
        chk("div0_z", dut.z, {32'd7, 32'hFFFFFFFF});

        load_y(32'h80000001);
        load_reg(4, 32'd1);
        alu_z(4, 4'b0100);
        chk("shr_z", dut.z, 64'h40000000);
        alu_z(4, 4'b0101);
        chk("shra_z", dut.z, 64'hC0000000);
        alu_z(4, 4'b0111);
        chk("ror_z", dut.z, 64'hC0000000);
        alu_z(4, 4'b1000);
        chk("rol_z", dut.z, 64'h00000003);

        // PC loads pre-edge Z while Z itself updates on the same edge
        load_reg(6, 32'd100);
        dif.BusDataSelect = 5'd19;
        dif.e_PC = 1'b1;
        dif.e_Z = 1'b1;
        dif.incPC = 1'b1;
        tick();
        chk("same_edge_pc", {32'h0, dut.pc}, 64'h3);
        chk("same_edge_z", dut.z, 64'h4);

        load_y(32'hFFFFFFF9);
        load_reg(7, 32'hF0F0_1234);
        load_reg(8, 32'd37);
        for (int op = 0; op < 16; op++) begin
            alu_z(7, 4'(op));
            alu_z(2, 4'(op));
            alu_z(8, 4'(op));
        end
        alu_z(23, 4'b1101);
        chk("sel23_z", dut.z, 64'h0);
        alu_z(2, 4'b1010);
        chk("div_neg_z", dut.z, {32'hFFFFFFFF, 32'hFFFFFFFD});

        for (int i = 0; i < 23; i++) begin
            dif.BusDataSelect = 5'(i);
            dif.GP_addr = 4'(15 - (i % 16));
            dif.e_GP = 1'b1;
            dif.e_MAR = 1'b1;
            tick();
        end

        clear = 1'b1;
        dif.BusDataSelect = 5'd21;
        dif.e_PC = 1'b1;
        dif.e_GP = 1'b1;
        dif.GP_addr = 4'd9;
        dif.e_MDR = 1'b1;
        dif.MDR_read = 1'b1;
        dif.Mdatain = 32'hDEADBEEF;
        tick();
        chk("clear_pc", {32'h0, dut.pc}, 64'h0);
        chk("clear_mdr", {32'h0, dut.mdr}, 64'h0);
        tick();

        @(negedge clock);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
